// File: rtl/multiphase_pwm_interleaver_pkg.sv
// Shared types and elaboration helpers for the multiphase PWM interleaver.
package pwm_pkg;

    typedef enum logic [1:0] {IDLE, DIV, STEP, ARMED} cfg_state_t;

    function automatic int nph_width(input int max_phases);
        return $clog2(max_phases + 1);
    endfunction

    function automatic int rst_offset(input int k, input int period,
                                      input int phases);
        return (k * period) / phases;
    endfunction

endpackage

// File: rtl/multiphase_pwm_interleaver_seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, W-cycle latency.
module seq_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);
    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] r_left;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_dvs;
    logic [W:0]    w_shift;
    logic [W:0]    w_trial;
    logic          w_fit;

    assign w_shift = {r_rem, r_quo[W-1]};
    assign w_fit   = w_shift >= {1'b0, r_dvs};
    assign w_trial = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_left <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
        end else if (start) begin
            r_left <= CW'(W);
            r_quo  <= dividend;
            r_rem  <= '0;
            r_dvs  <= divisor;
        end else if (r_left != '0) begin
            r_left <= r_left - CW'(1);
            r_rem  <= w_fit ? w_trial[W-1:0] : w_shift[W-1:0];
            r_quo  <= {r_quo[W-2:0], w_fit};
        end
    end

    // Asserted during the final iteration; results are valid the next cycle.
    assign done      = r_left == CW'(1);
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/multiphase_pwm_interleaver.sv
// Runtime-programmable interleaved PWM with glitch-free reconfiguration.
module multiphase_pwm_interleaver
    import pwm_pkg::*;
#(
    parameter int MAX_PHASES = 4,
    parameter int PERIOD_W   = 8,
    parameter int RST_PERIOD = 128,
    parameter int NPH_W      = nph_width(MAX_PHASES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PERIOD_W-1:0]   duty,
    input  logic                  cfg_load,
    input  logic [PERIOD_W-1:0]   cfg_period,
    input  logic [NPH_W-1:0]      cfg_nph,
    output logic                  cfg_busy,
    output logic                  cfg_err,
    output logic                  sync,
    output logic [MAX_PHASES-1:0] pwm_ph
);
    cfg_state_t r_state;
    cfg_state_t w_state_nxt;

    logic [PERIOD_W-1:0]   r_per;
    logic [PERIOD_W-1:0]   r_cnt;
    logic [PERIOD_W-1:0]   r_duty_a;
    logic [PERIOD_W-1:0]   r_per_n;
    logic [NPH_W-1:0]      r_nph;
    logic [NPH_W-1:0]      r_nph_n;
    logic [NPH_W-1:0]      r_k;
    logic [PERIOD_W-1:0]   r_off  [MAX_PHASES];
    logic [PERIOD_W-1:0]   r_offn [MAX_PHASES];
    logic [PERIOD_W-1:0]   r_prev;
    logic [PERIOD_W:0]     r_acc;
    logic [MAX_PHASES-1:0] r_pwm;
    logic                  r_sync;
    logic                  r_err;

    logic                  w_wrap;
    logic                  w_req_ok;
    logic [NPH_W-1:0]      w_nph_req;
    logic                  w_div_done;
    logic [PERIOD_W-1:0]   w_quo;
    logic [PERIOD_W-1:0]   w_rem;
    logic [PERIOD_W:0]     w_sum;
    logic [PERIOD_W:0]     w_nph_ext;
    logic                  w_carry;
    logic [PERIOD_W:0]     w_acc_nxt;
    logic [PERIOD_W-1:0]   w_off_nxt;
    logic [MAX_PHASES-1:0] w_pwm;

    assign w_wrap   = en && (r_cnt == r_per - PERIOD_W'(1));
    assign w_req_ok = cfg_load && (r_state == IDLE)
                   && (cfg_period >= PERIOD_W'(2));

    always_comb begin
        w_nph_req = cfg_nph;
        if (cfg_nph == '0)
            w_nph_req = NPH_W'(1);
        else if (cfg_nph > NPH_W'(MAX_PHASES))
            w_nph_req = NPH_W'(MAX_PHASES);
    end

    seq_divider #(.W(PERIOD_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_req_ok),
        .dividend  (cfg_period),
        .divisor   (PERIOD_W'(w_nph_req)),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // Bresenham step: acc tracks (k*r) mod nph, carry bumps the offset.
    assign w_nph_ext = (PERIOD_W+1)'(r_nph_n);
    assign w_sum     = r_acc + {1'b0, w_rem};
    assign w_carry   = w_sum >= w_nph_ext;
    assign w_acc_nxt = w_carry ? w_sum - w_nph_ext : w_sum;
    assign w_off_nxt = r_prev + w_quo + PERIOD_W'(w_carry);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  if (w_req_ok) w_state_nxt = DIV;
            DIV:   if (w_div_done)
                       w_state_nxt = (MAX_PHASES > 1) ? STEP : ARMED;
            STEP:  if (r_k == NPH_W'(MAX_PHASES - 1))
                       w_state_nxt = ARMED;
            ARMED: if (w_wrap) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_per    <= PERIOD_W'(RST_PERIOD);
            r_nph    <= NPH_W'(MAX_PHASES);
            r_duty_a <= '0;
            r_cnt    <= '0;
            r_per_n  <= '0;
            r_nph_n  <= '0;
            r_k      <= '0;
            r_prev   <= '0;
            r_acc    <= '0;
            for (int k = 0; k < MAX_PHASES; k++) begin
                r_off[k]  <= PERIOD_W'(rst_offset(k, RST_PERIOD, MAX_PHASES));
                r_offn[k] <= '0;
            end
        end else begin
            if (en)
                r_cnt <= w_wrap ? '0 : r_cnt + PERIOD_W'(1);
            if (w_wrap)
                r_duty_a <= duty;
            if (w_req_ok) begin
                r_per_n <= cfg_period;
                r_nph_n <= w_nph_req;
            end
            if (r_state == DIV && w_div_done) begin
                r_k    <= NPH_W'(1);
                r_prev <= '0;
                r_acc  <= '0;
            end
            if (r_state == STEP) begin
                for (int k = 1; k < MAX_PHASES; k++)
                    if (r_k == NPH_W'(k))
                        r_offn[k] <= w_off_nxt;
                r_prev <= w_off_nxt;
                r_acc  <= w_acc_nxt;
                r_k    <= r_k + NPH_W'(1);
            end
            // Commit lands on the wrap edge so the new period starts at cnt=0.
            if (r_state == ARMED && w_wrap) begin
                r_per <= r_per_n;
                r_nph <= r_nph_n;
                r_off <= r_offn;
            end
        end
    end

    for (genvar k = 0; k < MAX_PHASES; k++) begin : g_ph
        logic [PERIOD_W:0] w_dist;
        assign w_dist = (r_cnt >= r_off[k])
                      ? {1'b0, r_cnt} - {1'b0, r_off[k]}
                      : {1'b0, r_cnt} + {1'b0, r_per} - {1'b0, r_off[k]};
        assign w_pwm[k] = en && (NPH_W'(k) < r_nph)
                       && (w_dist < {1'b0, r_duty_a});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm  <= '0;
            r_sync <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_pwm  <= w_pwm;
            r_sync <= en && (r_cnt == '0);
            r_err  <= cfg_load && ((r_state != IDLE)
                                || (cfg_period < PERIOD_W'(2)));
        end
    end

    assign cfg_busy = r_state != IDLE;
    assign cfg_err  = r_err;
    assign sync     = r_sync;
    assign pwm_ph   = r_pwm;

endmodule

// File: doc/multiphase_pwm_interleaver.md
# multiphase_pwm_interleaver

Counter-based multiphase PWM generator that drives up to MAX_PHASES interleaved gate signals with the same duty, evenly phase-shifted across one switching period. Successor to the fixed shift-register phase shifter: the period, the active phase count and the duty are all runtime-programmable. Phase shedding and period changes are applied glitch-free at a period boundary. It sits between the digital compensator (duty source) and the dead-time/gate-driver stage of the multi-phase buck.

## Interface
- MAX_PHASES, 4: number of physical phase outputs; must be at least 1.
- PERIOD_W, 8: width of the period/duty/counter fields.
- RST_PERIOD, 128: active period after reset; legal range is 2..2^PERIOD_W-1.
- NPH_W, $clog2(MAX_PHASES+1): width of the phase-count field (derived).
- clk  in  1  single clock; everything is synchronous to its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  tick enable; counter advances only when en=1.
- duty  in  PERIOD_W  on-ticks per period; sampled at every period boundary.
- cfg_load  in  1  one-cycle request to load cfg_period and cfg_nph.
- cfg_period  in  PERIOD_W  requested period in ticks.
- cfg_nph  in  NPH_W  requested active phase count.
- cfg_busy  out  1  reconfiguration in progress.
- cfg_err  out  1  one-cycle pulse when a request is rejected.
- sync  out  1  one-cycle pulse at the period start of phase 0.
- pwm_ph  out  MAX_PHASES  registered phase outputs.

## Operation
- Active configuration registers: per (period), nph, duty_a, off[k] for k in 0..MAX_PHASES-1.
  - Reset values: per=RST_PERIOD, nph=MAX_PHASES, duty_a=0, off[k]=floor(k*RST_PERIOD/MAX_PHASES).
- Counter cnt:
  - Resets to 0. When en=1 it runs 0..per-1 and wraps; when en=0 it holds.
  - Wrap event W: en=1 and cnt==per-1.
  - On W, duty_a<=duty.
- Output for phase k, computed from cnt:
  - d = cnt-off[k] if cnt>=off[k], else cnt+per-off[k]. Use PERIOD_W+1 bit arithmetic.
  - pwm_ph[k] = en & (k<nph) & (d<duty_a).
  - duty_a>=per gives constant 1 on every active phase; duty_a=0 gives constant 0.
  - Unused phases (k>=nph) are held at 0.
- Request normalisation on cfg_load: cfg_nph=0 is treated as 1; cfg_nph>MAX_PHASES is clamped to MAX_PHASES.
- Request rejection: cfg_err pulses and nothing else changes if either
  - cfg_period<2, or
  - cfg_load arrives while cfg_busy=1 (first request wins).
- Reconfiguration FSM:
  - IDLE: on a valid cfg_load, latch per_n and nph_n, set cfg_busy, go to DIV.
  - DIV: iterative restoring divide per_n/nph_n, one quotient bit per cycle, exactly PERIOD_W cycles. Produces q and r. Go to STEP.
  - STEP: Bresenham accumulation, MAX_PHASES-1 cycles, one phase per cycle.
    - offn[0]=0.
    - offn[k]=offn[k-1]+q+carry, where carry=1 if acc+r>=nph_n; acc wraps by subtracting nph_n.
    - Result is offn[k]=floor(k*per_n/nph_n). Entries for k>=nph_n are don't-care.
    - Go to ARMED.
  - ARMED: on W, commit per<=per_n, nph<=nph_n, off<=offn, clear cfg_busy, go to IDLE. cnt wraps to 0 on the same edge.
- The committed period starts cleanly at cnt=0. There are no runt pulses and no partial period at the old offsets.
- rst in any state returns the block to IDLE with reset values. Any pending request is discarded and cfg_busy drops.

## Timing
- pwm_ph and sync are registered: the output for counter value c appears one cycle after cnt==c.
- sync=1 for exactly one cycle per period: the cycle after cnt==0 with en=1. It is 0 while en=0.
- Reset values of outputs: pwm_ph=0, sync=0, cfg_busy=0, cfg_err=0.
- cfg_load accepted in cycle t:
  - cfg_busy=1 from t+1.
  - ARMED is reached at t+1+PERIOD_W+MAX_PHASES-1.
  - Commit happens at the first W at or after that cycle.
  - cfg_busy=0 in the cycle after the commit edge.
- cfg_err is high in cycle t+1 for a request rejected in cycle t.
- en=0 during ARMED delays the commit until the next W. DIV and STEP still progress while en=0.
- A duty change takes effect from the period following the next W.
- cfg_load in the same cycle as W while in IDLE is accepted; it commits at a later wrap, never at that W.

## Structure
- Package pwm_pkg:
  - cfg_state_t enum {IDLE, DIV, STEP, ARMED}.
  - A function for the reset offsets, k*RST_PERIOD/MAX_PHASES.
  - The NPH_W derivation.
- Sub-module seq_divider: PERIOD_W-bit iterative restoring divider.
  - Inputs: start, dividend, divisor.
  - Outputs: done, quotient, remainder.
  - Fixed PERIOD_W-cycle latency.
- Top level holds the counter, the phase comparators, the offset accumulator and the FSM.

## Test plan
- Reset defaults, then en=1 with duty=32:
  - rising edges of pwm_ph[0..3] at cnt 0/32/64/96, each high for 32 ticks;
  - one sync pulse every 128 cycles.
- cfg_load with period=100, nph=3 mid-period:
  - cfg_busy rises next cycle and old waveforms continue unchanged until the wrap;
  - afterwards offsets are 0/33/66, pwm_ph[3]=0, and the period is 100 cycles.
- duty=0, then duty=200 with per=128:
  - all outputs 0 for a full period, then all active outputs 1;
  - changes are observed only after a wrap.
- cfg_period=1 → cfg_err one cycle with no state change; a second cfg_load during DIV → cfg_err while the first request still commits.
- cfg_nph=0 → behaves as 1 phase; cfg_nph=7 with MAX_PHASES=4 → 4 phases.
- rst asserted during DIV → cfg_busy=0 next cycle and outputs 0, and the reset configuration is restored; en toggling low freezes cnt and forces pwm_ph=0.
